key_event_queue: RTL and testbench

//  Sits directly downstream of the keypad decoder. Debounces the decoded key code.

---
 rtl/key_event_queue_pkg.sv | 16 +
 rtl/key_event_queue_if.sv | 12 +
 rtl/key_event_queue_fifo.sv | 45 ++++
 rtl/key_event_queue.sv | 134 +++++++++++++
 tb/tb_key_event_queue.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/key_event_queue_pkg.sv
// Shared types for the key event queue: event kinds and the FIFO entry format.
package key_evt_pkg;
  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_t;

  typedef struct packed {
    evt_type_t        typ;
    logic [KEY_W-1:0] code;
  } key_evt_t;
endpackage

// File: rtl/key_event_queue_if.sv
// Event stream handshake between the key event queue and its consumer.
interface key_event_queue_if;
  import key_evt_pkg::*;

  logic             evt_valid;
  evt_type_t        evt_type;
  logic [KEY_W-1:0] evt_code;
  logic             evt_ready;

  modport master (output evt_valid, evt_type, evt_code, input evt_ready);
  modport slave  (input evt_valid, evt_type, evt_code, output evt_ready);
endinterface

// File: rtl/key_event_queue_fifo.sv
// Show-ahead FIFO of key events; pointers carry one extra wrap bit.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  key_evt_t din,
  input  logic     pop,
  output key_evt_t head,
  output logic     full,
  output logic     empty,
  output logic [AW:0] fill
);
  key_evt_t    mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot a push into a full FIFO needs
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    fill    = wr_q - rd_q;
    head    = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/key_event_queue.sv
// Debounces decoded key levels into PRESS/RELEASE/REPEAT events and queues them.
// Key code width comes from key_evt_pkg::KEY_W so it always matches the FIFO entry.
module key_event_queue
  import key_evt_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DEBOUNCE_CYC = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [KEY_W-1:0]        key_code,
  input  logic                    key_down,
  input  logic                    ovf_clr,
  output logic                    ovf,
  output logic [$clog2(DEPTH):0]  fill,
  key_event_queue_if.master       evt
);
  localparam int SW      = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic             samp_down_q, samp_down_d, comm_down_q, comm_down_d;
  logic [KEY_W-1:0] samp_code_q, samp_code_d, comm_code_q, comm_code_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [RW-1:0]    rpt_q, rpt_d;
  logic             pend_q, pend_d, ovf_q, ovf_d;
  logic [KEY_W-1:0] pend_code_q, pend_code_d;

  logic [KEY_W-1:0] s_code;
  logic             same, differ, commit, rpt_fire, push, pop, full, empty;
  key_evt_t         push_evt, head;

  always_comb begin
    s_code      = key_down ? key_code : '0;
    same        = (key_down == samp_down_q) && (s_code == samp_code_q);
    differ      = (key_down != comm_down_q) || (s_code != comm_code_q);
    samp_down_d = key_down;
    samp_code_d = s_code;
    if (!same)                              stab_d = SW'(1);
    else if (stab_q == SW'(DEBOUNCE_CYC))   stab_d = stab_q;
    else                                    stab_d = stab_q + 1'b1;
    commit      = differ && (stab_d == SW'(DEBOUNCE_CYC));

    // repeat timer only runs while the held key matches the committed one
    rpt_fire = 1'b0;
    rpt_d    = rpt_q;
    if (comm_down_q && !differ) begin
      if (rpt_q <= RW'(1)) begin
        rpt_fire = 1'b1;
        rpt_d    = RW'(REPEAT_RATE);
      end else begin
        rpt_d = rpt_q - 1'b1;
      end
    end

    comm_down_d = comm_down_q;
    comm_code_d = comm_code_q;
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    push        = 1'b0;
    push_evt    = '0;
    if (pend_q) begin
      push     = 1'b1;
      push_evt = '{typ: EVT_PRESS, code: pend_code_q};
    end
    if (commit) begin
      comm_down_d = key_down;
      comm_code_d = s_code;
      if (!comm_down_q) begin
        push_evt = pend_q ? push_evt : '{typ: EVT_PRESS, code: s_code};
        rpt_d    = RW'(REPEAT_DELAY);
      end else begin
        push_evt = pend_q ? push_evt : '{typ: EVT_RELEASE, code: comm_code_q};
        // key-to-key change: the PRESS for the new key follows next cycle
        if (key_down) begin
          pend_d      = 1'b1;
          pend_code_d = s_code;
          rpt_d       = RW'(REPEAT_DELAY);
        end
      end
      push = 1'b1;
    end else if (rpt_fire && !pend_q) begin
      push     = 1'b1;
      push_evt = '{typ: EVT_REPEAT, code: comm_code_q};
    end

    pop   = evt.evt_valid && evt.evt_ready;
    ovf_d = ovf_clr ? 1'b0 : ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_down_q <= 1'b0;
      samp_code_q <= '0;
      stab_q      <= '0;
      comm_down_q <= 1'b0;
      comm_code_q <= '0;
      rpt_q       <= '0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      samp_down_q <= samp_down_d;
      samp_code_q <= samp_code_d;
      stab_q      <= stab_d;
      comm_down_q <= comm_down_d;
      comm_code_q <= comm_code_d;
      rpt_q       <= rpt_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      ovf_q       <= ovf_d;
    end
  end

  key_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_evt),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  assign evt.evt_valid = !empty;
  assign evt.evt_type  = head.typ;
  assign evt.evt_code  = head.code;
  assign ovf           = ovf_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Directed and random stimulus against an event-level model of the key queue.
module tb_key_event_queue;
  import key_evt_pkg::*;

  localparam int DEPTH = 8, DEB = 4, RDLY = 20, RRATE = 5;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] key_code = '0;
  logic       key_down = 1'b0, ovf_clr = 1'b0, ovf;
  logic [3:0] fill;

  key_event_queue_if ifc();

  key_event_queue #(.DEPTH(DEPTH), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_down(key_down),
    .ovf_clr(ovf_clr), .ovf(ovf), .fill(fill), .evt(ifc)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // model: key state 0 = up, k+1 = key k held; events encoded type*16+code
  int m_last, m_run, m_comm, m_held, m_pend_key;
  bit m_pend, m_ovf;
  int mq[$];
  int log_q[$];
  int exp_q[$];

  function automatic int ev(int t, int c);
    return t * 16 + c;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_last = 0; m_run = 0; m_comm = 0; m_held = 0;
    m_pend = 0; m_pend_key = 0; m_ovf = 0;
    mq.delete();
  endtask

  task automatic m_step();
    int s, e;
    bit pop;
    s = key_down ? int'(key_code) + 1 : 0;
    m_run  = (s == m_last) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    m_last = s;
    e = -1;
    if (m_pend) begin
      e = ev(1, m_pend_key);
      m_pend = 0;
    end
    if (m_run >= DEB && s != m_comm) begin
      if (e < 0) e = (m_comm == 0) ? ev(1, s - 1) : ev(2, m_comm - 1);
      if (m_comm != 0 && s != 0) begin
        m_pend = 1;
        m_pend_key = s - 1;
      end
      m_held = 0;
      m_comm = s;
    end else if (m_comm != 0 && s == m_comm) begin
      m_held++;
      if (e < 0 && m_held >= RDLY && (m_held - RDLY) % RRATE == 0) e = ev(3, m_comm - 1);
    end
    pop = (mq.size() > 0) && ifc.evt_ready;
    if (e >= 0 && mq.size() == DEPTH && !pop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (pop) void'(mq.pop_front());
    if (e >= 0 && mq.size() < DEPTH) mq.push_back(e);
  endtask

  task automatic cyc();
    m_step();
    if (ifc.evt_valid && ifc.evt_ready) log_q.push_back(ev(int'(ifc.evt_type), int'(ifc.evt_code)));
    @(posedge clk); #1;
    chk("evt_valid", ifc.evt_valid, mq.size() != 0);
    chk("fill", fill, mq.size());
    chk("ovf", ovf, m_ovf);
    if (mq.size() != 0) begin
      chk("evt_type", ifc.evt_type, mq[0] / 16);
      chk("evt_code", ifc.evt_code, mq[0] % 16);
    end
  endtask

  task automatic drive(bit d, int code, int n);
    key_down = d;
    key_code = code[3:0];
    repeat (n) cyc();
  endtask

  task automatic chk_log(string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk(tag, log_q[i], exp_q[i]);
  endtask

  initial begin
    int rl, n;
    m_reset();
    ifc.evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ifc.evt_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_type", ifc.evt_type, 0);
    chk("rst_code", ifc.evt_code, 0);
    rst_n = 1'b1;

    // short glitch never commits
    drive(1, 5, 3);
    drive(0, 0, 10);
    chk("t1_fill", fill, 0);

    // hold with auto-repeat
    ifc.evt_ready = 1'b1;
    log_q.delete();
    drive(1, 5, 40);
    drive(0, 0, 10);
    exp_q = {'h15, 'h35, 'h35, 'h35, 'h35, 'h25};
    chk_log("t2_seq");

    // direct key-to-key change
    log_q.delete();
    drive(1, 2, 8);
    drive(1, 7, 8);
    drive(0, 0, 8);
    exp_q = {'h12, 'h22, 'h17, 'h27};
    chk_log("t3_seq");

    // overflow with consumer stalled
    ifc.evt_ready = 1'b0;
    log_q.delete();
    for (int k = 1; k <= 4; k++) begin
      drive(1, k, 6);
      drive(0, 0, 6);
    end
    drive(1, 9, 6);
    chk("t4_fill", fill, 8);
    chk("t4_ovf", ovf, 1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", ovf, 0);

    // push into full FIFO with simultaneous pop
    drive(0, 0, 3);
    ifc.evt_ready = 1'b1;
    cyc();
    ifc.evt_ready = 1'b0;
    chk("t5_fill", fill, 8);
    chk("t5_ovf", ovf, 0);
    ifc.evt_ready = 1'b1;
    drive(0, 0, 12);
    exp_q = {'h11, 'h21, 'h12, 'h22, 'h13, 'h23, 'h14, 'h24, 'h29};
    chk_log("t45_seq");

    // random levels, ready and clears
    rl = 0;
    for (int i = 0; i < 600; i++) begin
      if (rl == 0) begin
        key_down = 1'($urandom % 2);
        key_code = 4'($urandom % 16);
        rl = $urandom_range(1, 30);
      end
      rl--;
      ifc.evt_ready = (i < 300) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
      ovf_clr = ($urandom % 16 == 0);
      cyc();
    end
    ovf_clr = 1'b0;

    // async reset with events queued and a key held
    ifc.evt_ready = 1'b1;
    drive(0, 0, 20);
    ifc.evt_ready = 1'b0;
    drive(1, 1, 6);
    drive(0, 0, 6);
    drive(1, 2, 6);
    chk("t6_fill_pre", fill, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", ifc.evt_valid, 0);
    chk("t6_rst_fill", fill, 0);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n++;
      if (ifc.evt_valid) break;
    end
    chk("t6_press_lat", n, 4);
    chk("t6_press_type", ifc.evt_type, 1);
    chk("t6_press_code", ifc.evt_code, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
